// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer
//   On-chip event tracer. Register writebacks and data-memory reads/writes are
//   captured with a free-running timestamp into a DEPTH-entry ring buffer. A
//   debug host drains the buffer over a valid/ready port.
//
//   Optional build macro: TRACE_ADDR_FILTER_EN
//     Adds filt_lo/filt_hi. Memory events are kept only when
//     filt_lo <= addr <= filt_hi. REG events are not filtered.
//
// Ports
//   clk, reset                        clock and async active-low reset
//   trace_en, overwrite_mode          capture enable and full policy (1 = overwrite oldest)
//   reg_write_sig/reg_num/reg_data    register writeback
//   wr/rd/addr/wr_data/rd_data        data-memory access
//   out_valid/out_ready/out_*         head entry and handshake
//   count, drop_cnt, proto_err        occupancy, saturating drop counter, sticky wr&rd flag
module riscv_trace_buffer #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int DROP_W = 16,
    localparam int IDX_W = (ADDR_W > 5) ? ADDR_W : 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     overwrite_mode,
    input  logic                     reg_write_sig,
    input  logic [4:0]               reg_num,
    input  logic [31:0]              reg_data,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [31:0]              wr_data,
    input  logic [31:0]              rd_data,
`ifdef TRACE_ADDR_FILTER_EN
    input  logic [ADDR_W-1:0]        filt_lo,
    input  logic [ADDR_W-1:0]        filt_hi,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_type,
    output logic [TS_W-1:0]          out_ts,
    output logic [IDX_W-1:0]         out_idx,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] TYPE_REG  = 2'b00;
    localparam logic [1:0] TYPE_MEMW = 2'b01;
    localparam logic [1:0] TYPE_MEMR = 2'b10;

    typedef struct packed {
        logic [1:0]       typ;
        logic [TS_W-1:0]  ts;
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
    } entry_t;

    entry_t mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr1;
    logic [CNT_W-1:0]  count_q, count_d, free;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W:0]   drop_sum;
    logic              err_q, err_d;

    logic              addr_ok, ev_reg, ev_mem, pop, we0, we1;
    logic [1:0]        n_ev, n_push, n_drop, n_evict;
    entry_t            ent_reg, ent_mem, ent0, head;

`ifdef TRACE_ADDR_FILTER_EN
    assign addr_ok = (addr >= filt_lo) && (addr <= filt_hi);
`else
    assign addr_ok = 1'b1;
`endif

    always_comb begin
        ev_reg  = trace_en & reg_write_sig;
        ev_mem  = trace_en & (wr ^ rd) & addr_ok;
        pop     = (count_q != '0) & out_ready;
        // Slots available this edge; a pop frees its slot for a same-cycle push.
        free    = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
        n_ev    = {1'b0, ev_reg} + {1'b0, ev_mem};
        n_push  = n_ev;
        n_drop  = 2'd0;
        n_evict = 2'd0;
        if (CNT_W'(n_ev) > free) begin
            // free < n_ev <= 2 here, so free fits in two bits.
            if (overwrite_mode) n_evict = n_ev - free[1:0];
            else begin
                n_push = free[1:0];
                n_drop = n_ev - free[1:0];
            end
        end

        ent_reg = '{typ: TYPE_REG, ts: ts_q, idx: IDX_W'(reg_num), data: reg_data};
        ent_mem = '{typ: wr ? TYPE_MEMW : TYPE_MEMR, ts: ts_q, idx: IDX_W'(addr),
                    data: wr ? wr_data : rd_data};
        // REG takes the lower slot; in stop mode a single slot goes to REG.
        ent0    = ev_reg ? ent_reg : ent_mem;
        we0     = n_push != 2'd0;
        we1     = n_push == 2'd2;
        wr_ptr1 = wr_ptr_q + PTR_W'(1);

        wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop) + PTR_W'(n_evict);
        count_d  = count_q + CNT_W'(n_push) - CNT_W'(pop) - CNT_W'(n_evict);
        ts_d     = ts_q + TS_W'(1);

        drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(n_drop);
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        err_d    = err_q | (trace_en & wr & rd);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ts_q     <= '0;
            drop_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ts_q     <= ts_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
        end
    end

    // Storage is not reset; the output mux hides it while empty.
    always_ff @(posedge clk) begin
        if (we0) mem_q[wr_ptr_q] <= ent0;
        if (we1) mem_q[wr_ptr1]  <= ent_mem;
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = count_q != '0;
    assign out_type  = out_valid ? head.typ  : '0;
    assign out_ts    = out_valid ? head.ts   : '0;
    assign out_idx   = out_valid ? head.idx  : '0;
    assign out_data  = out_valid ? head.data : '0;
    assign count     = count_q;
    assign drop_cnt  = drop_q;
    assign proto_err = err_q;

endmodule
